// File: rtl/logic_74hc191.sv
// logic_74hc191: 4-bit synchronous up/down binary counter with
// terminal-count, ripple-carry and a registered terminal-count flag.
module logic_74hc191 #(
    parameter logic [3:0] RESET_VAL = 4'b0000
) (
    input  logic       CK,
    input  logic       nCLR,
    input  logic       nLOAD,
    input  logic       nCTEN,
    input  logic       DnU,
    input  logic [3:0] DATAIN,
    output logic [3:0] COUNTER,
    output logic       MAX_MIN,
    output logic       nRCO,
    output logic       TC_Q
);

    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       max_min;
    logic       tc_q;

    // Next count: load beats count, count beats hold.
    always_comb begin
        count_d = count_q;
        if (!nLOAD) begin
            count_d = DATAIN;
        end else if (!nCTEN) begin
            if (DnU) begin
                count_d = count_q - 4'd1;
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    // Count register with asynchronous clear to RESET_VAL.
    always_ff @(posedge CK or negedge nCLR) begin
        if (!nCLR) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal count depends on the current direction, so a DnU flip
    // moves MAX_MIN and nRCO without waiting for a clock edge.
    always_comb begin
        max_min = 1'b0;
        if (DnU) begin
            max_min = (count_q == 4'd0);
        end else begin
            max_min = (count_q == 4'd15);
        end
    end

    // Registered terminal count; deliberately not cleared, it settles
    // on the first edge after reset.
    always_ff @(posedge CK) begin
        tc_q <= max_min;
    end

    assign COUNTER = count_q;
    assign MAX_MIN = max_min;
    assign nRCO    = ~(max_min & ~nCTEN);
    assign TC_Q    = tc_q;

endmodule
